// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - two-requester req/ack arbiter in front of the single-port LC3 memory
module lc3_mem_arbiter #(
    parameter int WIDTH       = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [WIDTH-1:0]      r0_wdata,
    output logic                  r0_ack,
    output logic [WIDTH-1:0]      r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [WIDTH-1:0]      r1_wdata,
    output logic                  r1_ack,
    output logic [WIDTH-1:0]      r1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_we,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter reload: ACCESS lasts cnt+1 cycles, ending on cnt==0.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
    // With a single ACCESS cycle the write strobe is raised straight out of IDLE.
    localparam logic       WE_ON_ENTRY = (WAIT_CYCLES == 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  prio_q, prio_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  r0_ack_q, r0_ack_d;
    logic                  r1_ack_q, r1_ack_d;
    logic                  busy_q, busy_d;
    logic                  grant;

    // Next-state logic: arbitration, countdown, and registered-output precompute.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mem_we_d = 1'b0;
        r0_ack_d = 1'b0;
        r1_ack_d = 1'b0;
        // Lone requester wins; on a tie the prio holder wins.
        grant    = (r0_req && r1_req) ? prio_q : r1_req;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    owner_d  = grant;
                    addr_d   = grant ? r1_addr  : r0_addr;
                    we_d     = grant ? r1_we    : r0_we;
                    wdata_d  = grant ? r1_wdata : r0_wdata;
                    cnt_d    = CNT_LOAD;
                    mem_we_d = WE_ON_ENTRY & (grant ? r1_we : r0_we);
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Final cycle: memory read data is sampled on the same edge
                    // that commits the write, so writes return the old contents.
                    rdata_d  = mem_rdata;
                    r0_ack_d = ~owner_q;
                    r1_ack_d = owner_q;
                    state_d  = RESP;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    mem_we_d = (cnt_q == 4'd1) & we_q;
                end
            end
            RESP: begin
                prio_d  = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any in-flight access at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mem_we_q <= 1'b0;
            r0_ack_q <= 1'b0;
            r1_ack_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mem_we_q <= mem_we_d;
            r0_ack_q <= r0_ack_d;
            r1_ack_q <= r1_ack_d;
            busy_q   <= busy_d;
        end
    end

    assign r0_ack    = r0_ack_q;
    assign r1_ack    = r1_ack_q;
    assign r0_rdata  = rdata_q;
    assign r1_rdata  = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// tb/tb_lc3_mem_arbiter.sv - directed self-checking bench for lc3_mem_arbiter (WAIT_CYCLES 1 and 3)
module tb_lc3_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WAIT_CYCLES=1
    logic        a_rst, a_r0_req, a_r0_we, a_r1_req, a_r1_we;
    logic [15:0] a_r0_addr, a_r0_wdata, a_r1_addr, a_r1_wdata;
    logic        a_r0_ack, a_r1_ack, a_mem_we, a_busy;
    logic [15:0] a_r0_rdata, a_r1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    // Instance B: WAIT_CYCLES=3
    logic        b_rst, b_r0_req, b_r0_we, b_r1_req, b_r1_we;
    logic [15:0] b_r0_addr, b_r0_wdata, b_r1_addr, b_r1_wdata;
    logic        b_r0_ack, b_r1_ack, b_mem_we, b_busy;
    logic [15:0] b_r0_rdata, b_r1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    lc3_mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .r0_req(a_r0_req), .r0_we(a_r0_we), .r0_addr(a_r0_addr), .r0_wdata(a_r0_wdata),
        .r0_ack(a_r0_ack), .r0_rdata(a_r0_rdata),
        .r1_req(a_r1_req), .r1_we(a_r1_we), .r1_addr(a_r1_addr), .r1_wdata(a_r1_wdata),
        .r1_ack(a_r1_ack), .r1_rdata(a_r1_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    lc3_mem_arbiter #(.WIDTH(16), .ADDR_WIDTH(16), .WAIT_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(b_r0_wdata),
        .r0_ack(b_r0_ack), .r0_rdata(b_r0_rdata),
        .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata),
        .r1_ack(b_r1_ack), .r1_rdata(b_r1_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory models with a backdoor preload port, plus write-strobe counters.
    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];
    logic        bd_we_a = 1'b0, bd_we_b = 1'b0;
    logic [15:0] bd_addr = '0, bd_data = '0;
    int          we_cnt_a = 0, we_cnt_b = 0;

    assign a_mem_rdata = mem_a[a_mem_addr];
    assign b_mem_rdata = mem_b[b_mem_addr];

    always @(posedge clk) begin
        if (bd_we_a)       mem_a[bd_addr]    <= bd_data;
        else if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        if (bd_we_b)       mem_b[bd_addr]    <= bd_data;
        else if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        if (a_mem_we) we_cnt_a <= we_cnt_a + 1;
        if (b_mem_we) we_cnt_b <= we_cnt_b + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input bit sel_b, input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bd_addr = addr;
        bd_data = data;
        bd_we_a = ~sel_b;
        bd_we_b = sel_b;
        @(negedge clk);
        bd_we_a = 1'b0;
        bd_we_b = 1'b0;
    endtask

    // Waits (bounded) on the selected ack; n is the number of cycles since the call.
    task automatic wait_ack(input bit sel_b, input bit who, output int n);
        logic ack;
        n = 0;
        ack = 1'b0;
        while (!ack && n < 20) begin
            @(negedge clk);
            n++;
            ack = sel_b ? (who ? b_r1_ack : b_r0_ack) : (who ? a_r1_ack : a_r0_ack);
        end
        check("ack_seen", {31'd0, ack}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int       n, w0, cyc;
    logic     seen;
    logic     early_ack;

    initial begin
        a_rst = 1'b0; b_rst = 1'b0;
        a_r0_req = 0; a_r0_we = 0; a_r0_addr = 0; a_r0_wdata = 0;
        a_r1_req = 0; a_r1_we = 0; a_r1_addr = 0; a_r1_wdata = 0;
        b_r0_req = 0; b_r0_we = 0; b_r0_addr = 0; b_r0_wdata = 0;
        b_r1_req = 0; b_r1_we = 0; b_r1_addr = 0; b_r1_wdata = 0;

        poke(0, 16'h3000, 16'h1234);
        poke(0, 16'h4000, 16'h5555);
        poke(0, 16'h0010, 16'h0000);
        poke(0, 16'h0020, 16'h0000);
        poke(1, 16'h0005, 16'h00AA);
        poke(1, 16'h0030, 16'h1111);

        // Reset state
        check("rst_busy",   {31'd0, a_busy}, 0);
        check("rst_ack",    {30'd0, a_r1_ack, a_r0_ack}, 0);
        check("rst_mem_we", {31'd0, a_mem_we}, 0);
        check("rst_addr",   {16'd0, a_mem_addr}, 0);
        check("rst_wdata",  {16'd0, a_mem_wdata}, 0);
        check("rst_rdata",  {a_r0_rdata, a_r1_rdata}, 0);
        @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;

        // Read, r0 only, WAIT_CYCLES=1
        @(negedge clk);
        a_r0_req = 1; a_r0_we = 0; a_r0_addr = 16'h3000;
        @(negedge clk);
        check("rd0_c1_busy", {31'd0, a_busy}, 1);
        check("rd0_c1_ack",  {31'd0, a_r0_ack}, 0);
        check("rd0_c1_addr", {16'd0, a_mem_addr}, 32'h3000);
        @(negedge clk);
        check("rd0_c2_ack",   {31'd0, a_r0_ack}, 1);
        check("rd0_c2_rdata", {16'd0, a_r0_rdata}, 32'h1234);
        check("rd0_c2_r1ack", {31'd0, a_r1_ack}, 0);
        a_r0_req = 0;
        @(negedge clk);
        check("rd0_c3_busy", {31'd0, a_busy}, 0);
        check("rd0_c3_ack",  {31'd0, a_r0_ack}, 0);

        // Write then read, r1
        w0 = we_cnt_a;
        a_r1_req = 1; a_r1_we = 1; a_r1_addr = 16'h4000; a_r1_wdata = 16'hBEEF;
        wait_ack(0, 1, n);
        check("wr1_latency", n, 2);
        check("wr1_old",     {16'd0, a_r1_rdata}, 32'h5555);
        check("wr1_r0ack",   {31'd0, a_r0_ack}, 0);
        a_r1_req = 0;
        @(negedge clk);
        check("wr1_mem",     {16'd0, mem_a[16'h4000]}, 32'hBEEF);
        check("wr1_strobes", we_cnt_a - w0, 1);
        a_r1_req = 1; a_r1_we = 0;
        wait_ack(0, 1, n);
        check("rd1_rdata",   {16'd0, a_r1_rdata}, 32'hBEEF);
        a_r1_req = 0;
        @(negedge clk);
        check("rd1_strobes", we_cnt_a - w0, 1);

        // Simultaneous requests after reset: strict alternation, 3 cycles each
        a_rst = 1'b0;
        @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        a_r0_req = 1; a_r0_we = 0; a_r0_addr = 16'h3000;
        a_r1_req = 1; a_r1_we = 0; a_r1_addr = 16'h4000;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            seen = 1'b0;
            while (!seen && cyc < 20) begin
                @(negedge clk);
                cyc++;
                seen = a_r0_ack | a_r1_ack;
            end
            check("alt_seen",   {31'd0, seen}, 1);
            check("alt_owner",  {30'd0, a_r1_ack, a_r0_ack}, (k % 2) ? 32'd2 : 32'd1);
            check("alt_cycles", cyc, (k == 0) ? 32'd2 : 32'd3);
            check("alt_rdata",  {16'd0, a_r0_rdata}, (k % 2) ? 32'hBEEF : 32'h1234);
        end
        a_r0_req = 0; a_r1_req = 0;
        @(negedge clk);
        check("alt_idle", {31'd0, a_busy}, 0);

        // Request withdrawn mid-access
        w0 = we_cnt_a;
        a_r0_req = 1; a_r0_we = 1; a_r0_addr = 16'h0010; a_r0_wdata = 16'h7777;
        @(negedge clk);
        check("wd_c1_busy", {31'd0, a_busy}, 1);
        a_r0_req = 0; a_r0_addr = 16'h0020; a_r0_wdata = 16'hDEAD;
        @(negedge clk);
        check("wd_ack",     {31'd0, a_r0_ack}, 1);
        @(negedge clk);
        check("wd_mem",     {16'd0, mem_a[16'h0010]}, 32'h7777);
        check("wd_other",   {16'd0, mem_a[16'h0020]}, 32'h0000);
        check("wd_strobes", we_cnt_a - w0, 1);
        check("wd_idle",    {31'd0, a_busy}, 0);

        // WAIT_CYCLES=3 read
        w0 = we_cnt_b;
        b_r0_req = 1; b_r0_we = 0; b_r0_addr = 16'h0005;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("w3_busy",   {31'd0, b_busy}, 1);
            check("w3_ack",    {31'd0, b_r0_ack}, (c == 4) ? 32'd1 : 32'd0);
            check("w3_mem_we", {31'd0, b_mem_we}, 0);
        end
        check("w3_rdata", {16'd0, b_r0_rdata}, 32'h00AA);
        b_r0_req = 0;
        @(negedge clk);
        check("w3_idle",    {31'd0, b_busy}, 0);
        check("w3_strobes", we_cnt_b - w0, 0);

        // Reset mid-access (WAIT_CYCLES=3, r1 write)
        w0 = we_cnt_b;
        b_r1_req = 1; b_r1_we = 1; b_r1_addr = 16'h0030; b_r1_wdata = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        check("ra_busy_before", {31'd0, b_busy}, 1);
        b_rst = 1'b0;
        #1;
        check("ra_busy",   {31'd0, b_busy}, 0);
        check("ra_mem_we", {31'd0, b_mem_we}, 0);
        check("ra_addr",   {16'd0, b_mem_addr}, 0);
        check("ra_ack",    {30'd0, b_r1_ack, b_r0_ack}, 0);
        early_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            early_ack = early_ack | b_r0_ack | b_r1_ack;
        end
        check("ra_no_ack", {31'd0, early_ack}, 0);
        b_r0_req = 1; b_r0_we = 0; b_r0_addr = 16'h0005;
        b_rst = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            seen = b_r0_ack | b_r1_ack;
        end
        check("ra_first_seen",  {31'd0, seen}, 1);
        check("ra_first_owner", {30'd0, b_r1_ack, b_r0_ack}, 1);
        check("ra_first_cyc",   cyc, 4);
        b_r0_req = 0; b_r1_req = 0;
        @(negedge clk);
        @(negedge clk);
        check("ra_mem",     {16'd0, mem_b[16'h0030]}, 32'h1111);
        check("ra_strobes", we_cnt_b - w0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

- Shares the single-port LC3 memory between two requesters.
  - Requester 0 is the LC3 datapath.
  - Requester 1 is a loader/debug port.
- Uses a req/ack handshake, round-robin tie-breaking and a configurable number of memory wait cycles.
- Sits between the requesters and `LC3Memory`. It drives that module's `addr`, `DataWrite` and `WriteEn`, and receives its combinational `DataRead`.

## Interface
- `WIDTH`, 16, data word width.
- `ADDR_WIDTH`, 16, address width.
- `WAIT_CYCLES`, 1, ACCESS cycles per transaction; legal range 1–15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `r0_req`  in  1  requester 0 transaction request.
- `r0_we`  in  1  requester 0 write (1) / read (0).
- `r0_addr`  in  ADDR_WIDTH  requester 0 address.
- `r0_wdata`  in  WIDTH  requester 0 write data.
- `r0_ack`  out  1  one-cycle completion pulse for requester 0.
- `r0_rdata`  out  WIDTH  read data; valid while `r0_ack`=1.
- `r1_req`, `r1_we`, `r1_addr`, `r1_wdata`, `r1_ack`, `r1_rdata`: identical set for requester 1.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  WIDTH  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  WIDTH  combinational memory read data.
- `busy`  out  1  high in ACCESS and RESP.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ACCESS: drive memory, count down wait cycles.
  - RESP: pulse ack.
- Registers:
  - `state` (2 b)
  - `cnt` (4 b)
  - `owner` (1 b)
  - `prio` (1 b)
  - latched `addr` / `we` / `wdata`
  - `rdata`
- IDLE:
  - `req` is sampled every cycle.
  - One request asserted: that requester wins.
  - Both asserted: requester `prio` wins.
  - On a win, latch the winner's addr/we/wdata, set `owner`, load `cnt`=WAIT_CYCLES−1, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - `mem_addr`/`mem_wdata` come from the latched values.
  - `cnt` decrements each cycle.
  - On the final cycle (`cnt`==0):
    - `mem_we` = latched `we` (single-cycle write strobe).
    - `rdata` ← `mem_rdata`. For writes this captures the pre-write contents.
    - Go to RESP.
  - `mem_we`=0 on every non-final ACCESS cycle.
- RESP:
  - `rK_ack`=1 for `owner` only; the other ack stays 0.
  - `prio` ← ~`owner`.
  - Go to IDLE unconditionally.
- `r0_rdata` and `r1_rdata` both output the shared `rdata` register. The value is meaningful only with the requester's own ack.
- Requester protocol:
  - Hold `req` and its operands stable until ack.
  - Deassert `req` in the cycle after ack, unless issuing a new transaction.
  - A `req` still high in the IDLE cycle after RESP is treated as a new request.
- Requester inputs are not used after latching. Dropping `req` or changing operands mid-transaction does not abort it; the access completes and ack still pulses.
- IDLE outputs:
  - `mem_we`=0.
  - `mem_addr`/`mem_wdata` hold the last latched values.
- Reset (asynchronous, `rst`=0), all values take effect immediately:
  - `state`=IDLE, `cnt`=0, `owner`=0, `prio`=0.
  - Latched addr/wdata/we = 0, `rdata`=0.
  - Outputs: `r0_ack`=`r1_ack`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, both rdata = 0.
- Reset mid-ACCESS: the transaction is abandoned and no ack is issued. A write is suppressed if reset asserts before the final-cycle edge.

## Timing
- A request accepted at IDLE cycle T gives:
  - ACCESS in cycles T+1 … T+WAIT_CYCLES;
  - `mem_we` (writes) at cycle T+WAIT_CYCLES;
  - ack at cycle T+WAIT_CYCLES+1.
- Transaction latency from request to ack is WAIT_CYCLES+1 cycles. Minimum occupancy is WAIT_CYCLES+2 cycles (IDLE + ACCESS + RESP).
- Two continuously requesting masters alternate strictly, because `prio` flips on every RESP.
- No starvation: a pending requester waits at most one foreign transaction.
- `busy` is registered state decode: high from T+1 through T+WAIT_CYCLES+1.

## Test plan
- Read, r0 only:
  - Setup: WAIT_CYCLES=1, mem[0x3000]=0x1234.
  - Stimulus: `r0_req`=1, `r0_addr`=0x3000 at cycle 0.
  - Required: `r0_ack`=1 with `r0_rdata`=0x1234 at cycle 2; `r1_ack` stays 0.
- Write then read, r1:
  - Stimulus: r1 writes 0xBEEF to 0x4000, then reads 0x4000.
  - Required: `mem_we` high exactly one cycle per write; write ack `r1_rdata` = old contents; read ack returns 0xBEEF.
- Simultaneous requests after reset:
  - Stimulus: r0 and r1 assert together, both held.
  - Required: r0 acked first, then r1, then r0, … strictly alternating.
  - Required: per-transaction cycle count = WAIT_CYCLES+2.
- WAIT_CYCLES=3 read:
  - Stimulus: read of 0x0005 (=0x00AA) accepted at cycle 0.
  - Required: `busy` high cycles 1–4, ack at cycle 4, rdata=0x00AA; `mem_we`=0 throughout.
- Request withdrawn mid-access:
  - Stimulus: r0 drops `req` in cycle 1 of a write to 0x0010.
  - Required: write to 0x0010 still occurs; `r0_ack` still pulses.
- Reset mid-access:
  - Stimulus: WAIT_CYCLES=3, r1 write in flight; `rst`=0 asynchronously in the second ACCESS cycle.
  - Required: immediately `busy`=0, `mem_we`=0, `mem_addr`=0; no ack; memory unchanged; r0 wins first after reset release.
